// File: rtl/cmd_pkg.sv
// cmd_pkg: command packet, opcode/status codes and executor state type
package cmd_pkg;
  localparam int CMD_ADDR_W = 16;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ST_OK = 8'h4B;
  localparam logic [7:0] ST_ERR = 8'h45;
  localparam logic [7:0] ST_TIMEOUT = 8'h54;
  typedef struct packed {
    logic [7:0] opcode;
    logic [CMD_ADDR_W-1:0] addr;
    logic [31:0] data;
  } cmd_packet_t;
  typedef enum logic [2:0] {IDLE, DECODE, MEM_REQ, MEM_WAIT, RESP} exec_state_t;
endpackage

// File: rtl/cmd_executor_resp_serializer.sv
// resp_serializer: shifts a status byte plus optional 4 data bytes out MSB first under full backpressure
module resp_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [7:0]  status_i,
  input  logic [31:0] word_i,
  input  logic        with_data_i,
  input  logic        full_i,
  output logic        wr_en_o,
  output logic [7:0]  wr_data_o,
  output logic        done_o
);
  logic [39:0] shreg_q, shreg_d;
  logic [2:0] left_q, left_d;
  always_comb begin
    wr_en_o = (left_q != 3'd0) && !full_i && !rst;
    shreg_d = load_i ? {status_i, word_i} : wr_en_o ? {shreg_q[31:0], 8'h00} : shreg_q;
    left_d = load_i ? (with_data_i ? 3'd5 : 3'd1) : left_q - 3'(wr_en_o);
  end
  assign wr_data_o = shreg_q[39:32];
  assign done_o = wr_en_o && (left_q == 3'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      left_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      left_q <= left_d;
    end
  end
endmodule

// File: rtl/cmd_executor.sv
// cmd_executor: pops parsed commands, performs one memory word access and streams a status/data response
module cmd_executor
  import cmd_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_fifo_valid,
  input  cmd_packet_t       cmd_fifo_rd_data,
  output logic              cmd_fifo_rd_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              resp_fifo_full,
  output logic              resp_fifo_wr_en,
  output logic [7:0]        resp_fifo_wr_data,
  output logic              busy
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  exec_state_t state_q, state_d;
  cmd_packet_t cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ld, wd, ser_done, is_rd, is_wr, term;
  logic [7:0] st;
  assign is_rd = cmd_q.opcode == OP_READ;
  assign is_wr = cmd_q.opcode == OP_WRITE;
  assign term = cnt_q == TERM;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q + CW'(1);
    ld = 1'b0;
    wd = 1'b0;
    st = ST_OK;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_fifo_valid) begin
          cmd_d = cmd_fifo_rd_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cnt_d = '0;
        if (is_rd || is_wr) state_d = MEM_REQ;
        else begin
          ld = 1'b1;
          st = ST_ERR;
          state_d = RESP;
        end
      end
      MEM_REQ: begin
        if (mem_ready) begin
          cnt_d = '0;
          ld = is_wr;
          state_d = is_wr ? RESP : MEM_WAIT;
        end else if (term) begin
          ld = 1'b1;
          st = ST_TIMEOUT;
          state_d = RESP;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          ld = 1'b1;
          wd = 1'b1;
          state_d = RESP;
        end else if (term) begin
          ld = 1'b1;
          st = ST_TIMEOUT;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
    end
  end
  assign cmd_fifo_rd_en = (state_q == IDLE) && cmd_fifo_valid && !rst;
  assign mem_req = (state_q == MEM_REQ) && !rst;
  assign mem_we = mem_req && is_wr;
  assign mem_addr = ADDR_W'(cmd_q.addr);
  assign mem_wdata = cmd_q.data;
  assign busy = state_q != IDLE;
  resp_serializer u_ser (
    .clk(clk),
    .rst(rst),
    .load_i(ld),
    .status_i(st),
    .word_i(wd ? mem_rdata : 32'h0),
    .with_data_i(wd),
    .full_i(resp_fifo_full),
    .wr_en_o(resp_fifo_wr_en),
    .wr_data_o(resp_fifo_wr_data),
    .done_o(ser_done)
  );
endmodule

// File: tb/tb_cmd_executor.sv
// tb_cmd_executor: vector table, corner sequences and randomized commands against a behavioural model
module tb_cmd_executor;
  import cmd_pkg::*;
  localparam int TO = 16;
  typedef struct {
    cmd_packet_t pkt;
    int rdy;
    int rvd;
  } job_t;
  typedef struct {
    logic [7:0] op;
    logic [15:0] addr;
    logic [31:0] data;
    int rdy;
    int rvd;
    int n;
    logic [39:0] exp;
    int reqc;
    int lat;
  } vec_t;
  logic clk = 0, rst = 1;
  logic cmd_fifo_valid = 0, cmd_fifo_rd_en;
  cmd_packet_t cmd_fifo_rd_data = '0;
  logic mem_req, mem_we, mem_ready = 0, mem_rvalid = 0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0;
  logic resp_fifo_full = 0, resp_fifo_wr_en, busy;
  logic [7:0] resp_fifo_wr_data;
  cmd_executor #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_fifo_valid(cmd_fifo_valid), .cmd_fifo_rd_data(cmd_fifo_rd_data), .cmd_fifo_rd_en(cmd_fifo_rd_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_fifo_full(resp_fifo_full), .resp_fifo_wr_en(resp_fifo_wr_en),
    .resp_fifo_wr_data(resp_fifo_wr_data), .busy(busy)
  );
  always #5 clk = ~clk;
  job_t cq[$];
  job_t cur;
  logic [31:0] mem[int];
  logic [31:0] ref_mem[int];
  int cyc = 0, req_n = 0, req_total = 0, acc_n = 0, rv_at = -1;
  logic [31:0] rv_data = 0;
  int pop_cyc[$], byte_cyc[$];
  logic [7:0] bytes[$];
  logic full_force = 0, rand_full = 0;
  int n_chk = 0, n_fail = 0;
  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_zero(input string name);
    chk(name, {cmd_fifo_rd_en, mem_req, mem_we, mem_addr, mem_wdata, resp_fifo_wr_en, resp_fifo_wr_data, busy}, 64'h0);
  endtask
  task automatic clear_logs();
    bytes.delete();
    byte_cyc.delete();
    pop_cyc.delete();
    req_total = 0;
    acc_n = 0;
  endtask
  task automatic wait_done(input int n, input int limit);
    int k = 0;
    while (!(bytes.size() >= n && cq.size() == 0 && !busy) && k < limit) begin
      @(posedge clk); #2;
      k++;
    end
    chk("done_within_bound", k < limit, 1);
    repeat (3) begin @(posedge clk); #2; end
  endtask
  // Environment: command FIFO, memory responder and byte sink, all sampled mid-cycle
  initial begin
    cur.pkt = '0;
    cur.rdy = 0;
    cur.rvd = 1;
    forever begin
      @(negedge clk);
      cmd_fifo_valid = cq.size() != 0;
      if (cmd_fifo_valid) cmd_fifo_rd_data = cq[0].pkt;
      mem_ready = req_n >= cur.rdy;
      mem_rvalid = cyc == rv_at;
      mem_rdata = mem_rvalid ? rv_data : $urandom();
      resp_fifo_full = full_force || (rand_full && $urandom_range(0, 3) == 0);
      #1;
      if (cmd_fifo_rd_en) begin
        chk("pop_only_when_valid", cmd_fifo_valid, 1);
        chk("pop_only_when_idle", busy, 0);
        if (cq.size() != 0) cur = cq.pop_front();
        pop_cyc.push_back(cyc);
        req_n = 0;
        rv_at = -1;
      end
      if (mem_req) begin
        chk("mem_we", mem_we, cur.pkt.opcode == OP_WRITE);
        chk("mem_addr", mem_addr, cur.pkt.addr);
        chk("mem_wdata", mem_wdata, cur.pkt.data);
        req_total++;
        if (mem_ready) begin
          acc_n++;
          if (mem_we) mem[int'(mem_addr)] = mem_wdata;
          else begin
            rv_at = cyc + cur.rvd;
            rv_data = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : dflt(mem_addr);
          end
        end
        req_n++;
      end
      if (resp_fifo_wr_en) begin
        chk("push_only_when_not_full", resp_fifo_full, 0);
        bytes.push_back(resp_fifo_wr_data);
        byte_cyc.push_back(cyc);
      end
      if (rst) rv_at = -1;
      cyc++;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[12];
    job_t j;
    logic [7:0] expq[$];
    logic [31:0] w;
    int k;
    v[0]  = '{8'h57, 16'h0010, 32'hDEADBEEF, 0, 1, 1, 40'h4B00000000, 1, 3};
    v[1]  = '{8'h52, 16'h0010, 32'h0, 2, 3, 5, 40'h4BDEADBEEF, 3, 8};
    v[2]  = '{8'h33, 16'h0010, 32'h0, 0, 1, 1, 40'h4500000000, 0, 2};
    v[3]  = '{8'h52, 16'h0020, 32'h0, 99, 1, 1, 40'h5400000000, 16, 18};
    v[4]  = '{8'h57, 16'h0020, 32'h12345678, 1, 1, 1, 40'h4B00000000, 2, 4};
    v[5]  = '{8'h52, 16'h0020, 32'h0, 0, 1, 5, 40'h4B12345678, 1, 4};
    v[6]  = '{8'h57, 16'h0030, 32'hCAFEF00D, 15, 1, 1, 40'h4B00000000, 16, 18};
    v[7]  = '{8'h52, 16'h0030, 32'h0, 0, 16, 5, 40'h4BCAFEF00D, 1, 19};
    v[8]  = '{8'h52, 16'h0030, 32'h0, 0, 17, 1, 40'h5400000000, 1, 19};
    v[9]  = '{8'h57, 16'h0040, 32'h55AA55AA, 16, 1, 1, 40'h5400000000, 16, 18};
    v[10] = '{8'h52, 16'h0040, 32'h0, 0, 1, 5, 40'h4BC0DE0040, 1, 4};
    v[11] = '{8'h00, 16'h0040, 32'h0, 0, 1, 1, 40'h4500000000, 0, 2};
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_outputs");
    rst = 0;
    foreach (v[i]) begin
      clear_logs();
      j.pkt = {v[i].op, v[i].addr, v[i].data};
      j.rdy = v[i].rdy;
      j.rvd = v[i].rvd;
      cq.push_back(j);
      wait_done(v[i].n, 200);
      chk($sformatf("v%0d_nbytes", i), bytes.size(), v[i].n);
      for (int b = 0; b < v[i].n && b < bytes.size(); b++)
        chk($sformatf("v%0d_byte%0d", i, b), bytes[b], v[i].exp[39-8*b -: 8]);
      chk($sformatf("v%0d_pops", i), pop_cyc.size(), 1);
      chk($sformatf("v%0d_req_cycles", i), req_total, v[i].reqc);
      if (pop_cyc.size() > 0 && byte_cyc.size() > 0) begin
        chk($sformatf("v%0d_latency", i), byte_cyc[0] - pop_cyc[0], v[i].lat);
        chk($sformatf("v%0d_burst", i), byte_cyc[byte_cyc.size()-1] - byte_cyc[0], byte_cyc.size() - 1);
      end
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    // Timeout followed by a queued write that must run back-to-back
    clear_logs();
    j.pkt = {OP_READ, 16'h0020, 32'h0}; j.rdy = 99; j.rvd = 1; cq.push_back(j);
    j.pkt = {OP_WRITE, 16'h0050, 32'h11223344}; j.rdy = 0; j.rvd = 1; cq.push_back(j);
    wait_done(2, 200);
    chk("seqA_nbytes", bytes.size(), 2);
    if (bytes.size() == 2 && pop_cyc.size() == 2) begin
      chk("seqA_timeout_byte", bytes[0], ST_TIMEOUT);
      chk("seqA_ok_byte", bytes[1], ST_OK);
      chk("seqA_back_to_back_pop", pop_cyc[1], byte_cyc[0] + 1);
      chk("seqA_write_latency", byte_cyc[1] - pop_cyc[1], 3);
    end
    chk("seqA_pops", pop_cyc.size(), 2);
    chk("seqA_req_cycles", req_total, 17);
    chk("seqA_mem_written", mem.exists(16'h0050) ? mem[16'h0050] : 32'h0, 32'h11223344);
    // Response stalled by a full TX FIFO for 10 cycles after the status byte
    clear_logs();
    j.pkt = {OP_READ, 16'h0010, 32'h0}; j.rdy = 0; j.rvd = 1; cq.push_back(j);
    k = 0;
    while (bytes.size() < 1 && k < 100) begin @(posedge clk); #2; k++; end
    chk("seqB_first_byte_seen", k < 100, 1);
    full_force = 1;
    repeat (10) begin @(posedge clk); #2; end
    chk("seqB_no_push_while_full", bytes.size(), 1);
    full_force = 0;
    wait_done(5, 100);
    chk("seqB_nbytes", bytes.size(), 5);
    w = 32'hDEADBEEF;
    if (bytes.size() == 5) begin
      chk("seqB_status", bytes[0], ST_OK);
      for (int b = 0; b < 4; b++) chk($sformatf("seqB_data%0d", b), bytes[b+1], w[31-8*b -: 8]);
      chk("seqB_resume_gap", byte_cyc[1] - byte_cyc[0], 11);
      chk("seqB_tail_burst", byte_cyc[4] - byte_cyc[1], 3);
    end
    // Reset during the second command's MEM_WAIT with a third command queued
    clear_logs();
    j.pkt = {OP_WRITE, 16'h0060, 32'h55667788}; j.rdy = 0; j.rvd = 1; cq.push_back(j);
    j.pkt = {OP_READ, 16'h0060, 32'h0}; j.rdy = 0; j.rvd = 12; cq.push_back(j);
    j.pkt = {OP_WRITE, 16'h0070, 32'h99AABBCC}; j.rdy = 0; j.rvd = 1; cq.push_back(j);
    k = 0;
    while (acc_n < 2 && k < 100) begin @(posedge clk); #2; k++; end
    chk("seqC_read_accepted", k < 100, 1);
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    check_zero("seqC_outputs_after_rst");
    chk("seqC_no_pop_in_rst", pop_cyc.size(), 2);
    @(posedge clk); #2;
    chk("seqC_no_pop_in_rst2", pop_cyc.size(), 2);
    rst = 0;
    wait_done(2, 100);
    chk("seqC_nbytes", bytes.size(), 2);
    if (bytes.size() == 2) begin
      chk("seqC_byte0", bytes[0], ST_OK);
      chk("seqC_byte1", bytes[1], ST_OK);
    end
    chk("seqC_pops", pop_cyc.size(), 3);
    chk("seqC_third_write", mem.exists(16'h0070) ? mem[16'h0070] : 32'h0, 32'h99AABBCC);
    // Randomized back-to-back commands with random backpressure
    clear_logs();
    mem.delete();
    ref_mem.delete();
    rand_full = 1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      j.pkt.opcode = (k < 4) ? OP_READ : (k < 8) ? OP_WRITE : 8'($urandom_range(0, 255));
      j.pkt.addr = 16'($urandom_range(0, 7));
      j.pkt.data = $urandom();
      j.rdy = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
      j.rvd = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(1, 4);
      if (j.pkt.opcode == OP_WRITE) begin
        if (j.rdy >= TO) expq.push_back(ST_TIMEOUT);
        else begin
          ref_mem[int'(j.pkt.addr)] = j.pkt.data;
          expq.push_back(ST_OK);
        end
      end else if (j.pkt.opcode == OP_READ) begin
        if (j.rdy >= TO || j.rvd > TO) expq.push_back(ST_TIMEOUT);
        else begin
          w = ref_mem.exists(int'(j.pkt.addr)) ? ref_mem[int'(j.pkt.addr)] : dflt(j.pkt.addr);
          expq.push_back(ST_OK);
          for (int b = 3; b >= 0; b--) expq.push_back(w[8*b +: 8]);
        end
      end else expq.push_back(ST_ERR);
      cq.push_back(j);
    end
    wait_done(expq.size(), 6000);
    rand_full = 0;
    chk("rand_nbytes", bytes.size(), expq.size());
    chk("rand_pops", pop_cyc.size(), 40);
    for (int b = 0; b < expq.size() && b < bytes.size(); b++)
      chk($sformatf("rand_byte%0d", b), bytes[b], expq[b]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
